// File: rtl/axi4_slave_mem.sv
// AXI4 responder over a 64-bit RAM: one transaction at a time, FIXED/INCR/WRAP bursts with byte strobes.
// First R beat appears the cycle after the AR handshake; every channel holds its outputs until the master handshakes.
module axi4_slave_mem #(
  parameter int MEM_AW = 10,
  parameter int ID_W   = 4
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            i_awvalid,
  output logic            o_awready,
  input  logic [ID_W-1:0] i_awid,
  input  logic [31:0]     i_awaddr,
  input  logic [7:0]      i_awlen,
  input  logic [2:0]      i_awsize,
  input  logic [1:0]      i_awburst,
  input  logic            i_wvalid,
  output logic            o_wready,
  input  logic [63:0]     i_wdata,
  input  logic [7:0]      i_wstrb,
  input  logic            i_wlast,
  output logic            o_bvalid,
  input  logic            i_bready,
  output logic [ID_W-1:0] o_bid,
  output logic [1:0]      o_bresp,
  input  logic            i_arvalid,
  output logic            o_arready,
  input  logic [ID_W-1:0] i_arid,
  input  logic [31:0]     i_araddr,
  input  logic [7:0]      i_arlen,
  input  logic [2:0]      i_arsize,
  input  logic [1:0]      i_arburst,
  output logic            o_rvalid,
  input  logic            i_rready,
  output logic [ID_W-1:0] o_rid,
  output logic [63:0]     o_rdata,
  output logic [1:0]      o_rresp,
  output logic            o_rlast
);

  typedef enum logic [1:0] {IDLE, WRITE, BRESP, READ} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   id_q;
  logic [31:0]       addr_q;
  logic [31:0]       addr_nxt;
  logic [31:0]       step;
  logic [31:0]       wrap_mask;
  logic [7:0]        len_q;
  logic [7:0]        cnt;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              err;
  logic [MEM_AW-1:0] widx;
  logic              aw_hs;
  logic              ar_hs;
  logic              w_hs;
  logic              r_hs;

  logic [63:0] mem [0:(1<<MEM_AW)-1];

  function automatic logic bad_cmd(input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    bad_cmd = (size > 3'd3) || (burst == 2'b11) ||
              ((burst == 2'b10) &&
               !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
  endfunction

  // AW has priority over AR when both are presented in IDLE.
  assign aw_hs = (state == IDLE) && i_awvalid;
  assign ar_hs = (state == IDLE) && !i_awvalid && i_arvalid;
  assign w_hs  = (state == WRITE) && i_wvalid;
  assign r_hs  = (state == READ) && i_rready;
  assign widx  = addr_q[MEM_AW+2:3];

  always_comb begin
    step      = 32'd1 << size_q;
    wrap_mask = (({24'd0, len_q} + 32'd1) << size_q) - 32'd1;
    case (burst_q)
      2'b01:   addr_nxt = addr_q + step;
      2'b10:   addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: addr_nxt = addr_q;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (aw_hs)      state_nxt = WRITE;
        else if (ar_hs) state_nxt = READ;
      end
      WRITE:   if (w_hs && (cnt == 8'd0)) state_nxt = BRESP;
      BRESP:   if (i_bready) state_nxt = IDLE;
      READ:    if (r_hs && (cnt == 8'd0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while arst is held so an aborted burst goes quiet at once.
  always_comb begin
    o_awready = 1'b0;
    o_arready = 1'b0;
    o_wready  = 1'b0;
    o_bvalid  = 1'b0;
    o_bid     = '0;
    o_bresp   = 2'b00;
    o_rvalid  = 1'b0;
    o_rid     = '0;
    o_rdata   = 64'd0;
    o_rresp   = 2'b00;
    o_rlast   = 1'b0;
    if (!arst) begin
      case (state)
        IDLE: begin
          o_awready = 1'b1;
          o_arready = !i_awvalid;
        end
        WRITE: o_wready = 1'b1;
        BRESP: begin
          o_bvalid = 1'b1;
          o_bid    = id_q;
          o_bresp  = err ? 2'b10 : 2'b00;
        end
        READ: begin
          o_rvalid = 1'b1;
          o_rid    = id_q;
          o_rdata  = err ? 64'd0 : mem[widx];
          o_rresp  = err ? 2'b10 : 2'b00;
          o_rlast  = (cnt == 8'd0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      id_q    <= '0;
      addr_q  <= 32'd0;
      len_q   <= 8'd0;
      cnt     <= 8'd0;
      size_q  <= 3'd0;
      burst_q <= 2'b00;
      err     <= 1'b0;
    end else if (aw_hs) begin
      id_q    <= i_awid;
      addr_q  <= i_awaddr;
      len_q   <= i_awlen;
      cnt     <= i_awlen;
      size_q  <= i_awsize;
      burst_q <= i_awburst;
      err     <= bad_cmd(i_awlen, i_awsize, i_awburst);
    end else if (ar_hs) begin
      id_q    <= i_arid;
      addr_q  <= i_araddr;
      len_q   <= i_arlen;
      cnt     <= i_arlen;
      size_q  <= i_arsize;
      burst_q <= i_arburst;
      err     <= bad_cmd(i_arlen, i_arsize, i_arburst);
    end else if (w_hs) begin
      addr_q <= addr_nxt;
      cnt    <= cnt - 8'd1;
      if (i_wlast != (cnt == 8'd0)) err <= 1'b1;
    end else if (r_hs) begin
      addr_q <= addr_nxt;
      cnt    <= cnt - 8'd1;
    end
  end

  // RAM has no reset: contents survive arst.
  always_ff @(posedge clk) begin
    if (w_hs && !err) begin
      for (int k = 0; k < 8; k++) begin
        if (i_wstrb[k]) mem[widx][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Bench for axi4_slave_mem: expected read beats are queued at AR issue and compared as R beats arrive.
module tb_axi4_slave_mem;

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        arst;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  int          checks = 0;
  int          errors = 0;
  int          stall_viol;
  beat_t       exp_q[$];
  beat_t       obs_q[$];
  logic [63:0] wq[$];

  wire [81:0] all_outs = {awready, arready, wready, bvalid, bid, bresp,
                          rvalid, rid, rdata, rresp, rlast};

  always #5 clk = ~clk;

  axi4_slave_mem #(.MEM_AW(10), .ID_W(4)) dut (
    .clk(clk), .arst(arst),
    .i_awvalid(awvalid), .o_awready(awready), .i_awid(awid), .i_awaddr(awaddr),
    .i_awlen(awlen), .i_awsize(awsize), .i_awburst(awburst),
    .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast),
    .o_bvalid(bvalid), .i_bready(bready), .o_bid(bid), .o_bresp(bresp),
    .i_arvalid(arvalid), .o_arready(arready), .i_arid(arid), .i_araddr(araddr),
    .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst),
    .o_rvalid(rvalid), .i_rready(rready), .o_rid(rid), .o_rdata(rdata),
    .o_rresp(rresp), .o_rlast(rlast)
  );

  // ---------------- bus drivers (no checking) ----------------
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output bit to);
    int n = 0;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    #1;
    while (!awready && n < 100) begin @(posedge clk); #1; n++; end
    to = !awready;
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output bit to);
    int n = 0;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    #1;
    while (!arready && n < 100) begin @(posedge clk); #1; n++; end
    to = !arready;
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic l, output bit to);
    int n = 0;
    wvalid = 1'b1; wdata = d; wstrb = s; wlast = l;
    #1;
    while (!wready && n < 100) begin @(posedge clk); #1; n++; end
    to = !wready;
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic recv_b(output logic [3:0] id, output logic [1:0] resp, output bit to);
    int n = 0;
    bready = 1'b1;
    #1;
    while (!bvalid && n < 100) begin @(posedge clk); #1; n++; end
    to = !bvalid; id = bid; resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                             input int last_at, output logic [3:0] b_id, output logic [1:0] b_resp,
                             output bit to);
    bit t;
    send_aw(id, addr, len, size, burst, t);
    to = t;
    for (int i = 0; i <= int'(len); i++) begin
      send_w(wq[i], strb, i == last_at, t);
      to |= t;
    end
    recv_b(b_id, b_resp, t);
    to |= t;
  endtask

  // Collects n beats into obs_q; with toggle set rready alternates starting low.
  task automatic recv_r(input int n, input bit toggle, output bit to);
    int          got = 0;
    int          cyc = 0;
    bit          stalled = 0;
    logic [63:0] pd;
    logic        pl;
    stall_viol = 0;
    rready = !toggle;
    while (got < n && cyc < 200) begin
      #1;
      if (rvalid) begin
        if (stalled && (rdata !== pd || rlast !== pl)) stall_viol++;
        if (rready) begin
          obs_q.push_back({rid, rdata, rresp, rlast});
          got++;
          stalled = 0;
        end else begin
          stalled = 1; pd = rdata; pl = rlast;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (toggle) rready = !rready;
    end
    rready = 1'b0;
    to = (got < n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (all_outs !== 82'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
    arst = 1'b0;
    #1;
    checks++;
    if ({awready, arready} !== 2'b11) begin
      errors++; $display("FAIL idle_readies: got %b want 11", {awready, arready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    logic [3:0] b_id; logic [1:0] b_resp; bit to; beat_t e, o;
    wq = '{64'hDEADBEEF_CAFEF00D};
    write_burst(4'h5, 32'h100, 8'd0, 3'd3, INCR, 8'hFF, 0, b_id, b_resp, to);
    checks++;
    if (to || {b_id, b_resp} !== {4'h5, 2'b00}) begin
      errors++; $display("FAIL single_b: got id %h resp %b timeout %0d want id 5 resp 00", b_id, b_resp, to);
    end
    send_ar(4'h3, 32'h100, 8'd0, 3'd3, INCR, to);
    checks++;
    if (to || rvalid !== 1'b1) begin
      errors++; $display("FAIL single_rvalid_next: got %b timeout %0d want 1", rvalid, to);
    end
    exp_q.push_back({4'h3, 64'hDEADBEEF_CAFEF00D, 2'b00, 1'b1});
    recv_r(1, 0, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL single_r: got no beat want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL single_r: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_incr_stall;
    logic [3:0] b_id; logic [1:0] b_resp; bit to; beat_t e, o;
    wq = {};
    for (int i = 1; i <= 8; i++) wq.push_back(64'(i));
    write_burst(4'h2, 32'h200, 8'd7, 3'd3, INCR, 8'hFF, 7, b_id, b_resp, to);
    checks++;
    if (to || {b_id, b_resp} !== {4'h2, 2'b00}) begin
      errors++; $display("FAIL incr_b: got id %h resp %b timeout %0d want id 2 resp 00", b_id, b_resp, to);
    end
    send_ar(4'h7, 32'h200, 8'd7, 3'd3, INCR, to);
    for (int i = 1; i <= 8; i++) exp_q.push_back({4'h7, 64'(i), 2'b00, i == 8});
    recv_r(8, 1, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL incr_r: got no beat want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL incr_r: got %h want %h", o, e); end
      end
    end
    checks++;
    if (stall_viol !== 0) begin
      errors++; $display("FAIL incr_stall_stable: got %0d changes want 0", stall_viol);
    end
  endtask

  task automatic test_wrap;
    logic [3:0] b_id; logic [1:0] b_resp; bit to; beat_t e, o;
    wq = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    write_burst(4'h4, 32'h218, 8'd3, 3'd3, WRAP, 8'hFF, 3, b_id, b_resp, to);
    checks++;
    if (to || b_resp !== 2'b00) begin
      errors++; $display("FAIL wrap_b: got resp %b timeout %0d want 00", b_resp, to);
    end
    // Words 0x218,0x200,0x208,0x210 hold A0..A3, so a linear read from 0x200 sees A1 A2 A3 A0.
    send_ar(4'h1, 32'h200, 8'd3, 3'd3, INCR, to);
    exp_q.push_back({4'h1, 64'hA1, 2'b00, 1'b0});
    exp_q.push_back({4'h1, 64'hA2, 2'b00, 1'b0});
    exp_q.push_back({4'h1, 64'hA3, 2'b00, 1'b0});
    exp_q.push_back({4'h1, 64'hA0, 2'b00, 1'b1});
    recv_r(4, 0, to);
    send_ar(4'h6, 32'h218, 8'd3, 3'd3, WRAP, to);
    for (int i = 0; i < 4; i++) exp_q.push_back({4'h6, 64'hA0 + 64'(i), 2'b00, i == 3});
    recv_r(4, 0, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL wrap_r: got no beat want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL wrap_r: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_strobe;
    logic [3:0] b_id; logic [1:0] b_resp; bit to; beat_t e, o;
    wq = '{64'hFFFF_FFFF_FFFF_FFFF};
    write_burst(4'h0, 32'h300, 8'd0, 3'd3, INCR, 8'hFF, 0, b_id, b_resp, to);
    wq = '{64'h0};
    write_burst(4'h0, 32'h300, 8'd0, 3'd3, INCR, 8'h0F, 0, b_id, b_resp, to);
    send_ar(4'h8, 32'h300, 8'd0, 3'd3, INCR, to);
    exp_q.push_back({4'h8, 64'hFFFFFFFF_00000000, 2'b00, 1'b1});
    recv_r(1, 0, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL strobe_r: got no beat want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL strobe_r: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_errors;
    logic [3:0] b_id; logic [1:0] b_resp; bit to; beat_t e, o;
    wq = '{64'h1234};
    write_burst(4'hB, 32'h300, 8'd0, 3'd3, RSVD, 8'hFF, 0, b_id, b_resp, to);
    checks++;
    if (to || {b_id, b_resp} !== {4'hB, 2'b10}) begin
      errors++; $display("FAIL rsvd_burst_b: got id %h resp %b timeout %0d want id b resp 10", b_id, b_resp, to);
    end
    wq = '{64'h11, 64'h22, 64'h33, 64'h44};
    write_burst(4'hC, 32'h400, 8'd3, 3'd3, INCR, 8'hFF, 1, b_id, b_resp, to);
    checks++;
    if (to || b_resp !== 2'b10) begin
      errors++; $display("FAIL early_wlast_b: got resp %b timeout %0d want 10 after 4 beats", b_resp, to);
    end
    send_ar(4'h9, 32'h300, 8'd0, 3'd3, INCR, to);
    exp_q.push_back({4'h9, 64'hFFFFFFFF_00000000, 2'b00, 1'b1});
    recv_r(1, 0, to);
    send_ar(4'hD, 32'h200, 8'd1, 3'd4, INCR, to);
    exp_q.push_back({4'hD, 64'h0, 2'b10, 1'b0});
    exp_q.push_back({4'hD, 64'h0, 2'b10, 1'b1});
    recv_r(2, 0, to);
    // WRAP with a length of 3 beats is illegal.
    send_ar(4'hE, 32'h200, 8'd2, 3'd3, WRAP, to);
    exp_q.push_back({4'hE, 64'h0, 2'b10, 1'b0});
    exp_q.push_back({4'hE, 64'h0, 2'b10, 1'b0});
    exp_q.push_back({4'hE, 64'h0, 2'b10, 1'b1});
    recv_r(3, 0, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL err_r: got no beat want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL err_r: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [3:0] b_id; logic [1:0] b_resp; bit to; beat_t e, o;
    awvalid = 1'b1; awid = 4'h1; awaddr = 32'h500; awlen = 8'd0; awsize = 3'd3; awburst = INCR;
    arvalid = 1'b1; arid = 4'h2; araddr = 32'h500; arlen = 8'd0; arsize = 3'd3; arburst = INCR;
    #1;
    checks++;
    if ({awready, arready} !== 2'b10) begin
      errors++; $display("FAIL sim_priority: got aw/ar ready %b want 10", {awready, arready});
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    send_w(64'h5555_AAAA_1234_5678, 8'hFF, 1'b1, to);
    checks++;
    if (arready !== 1'b0) begin
      errors++; $display("FAIL sim_ar_blocked_in_bresp: got %b want 0", arready);
    end
    recv_b(b_id, b_resp, to);
    checks++;
    if (to || {b_id, b_resp} !== {4'h1, 2'b00}) begin
      errors++; $display("FAIL sim_b: got id %h resp %b timeout %0d want id 1 resp 00", b_id, b_resp, to);
    end
    send_ar(4'h2, 32'h500, 8'd0, 3'd3, INCR, to);
    exp_q.push_back({4'h2, 64'h5555_AAAA_1234_5678, 2'b00, 1'b1});
    recv_r(1, 0, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL sim_r: got no beat want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL sim_r: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_arst_mid;
    logic [3:0] b_id; logic [1:0] b_resp; bit to; beat_t e, o;
    send_ar(4'h3, 32'h200, 8'd7, 3'd3, INCR, to);
    rready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (rvalid !== 1'b1 || rlast !== 1'b0) begin
      errors++; $display("FAIL arst_beat3_present: got rvalid %b rlast %b want 1 0", rvalid, rlast);
    end
    arst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (all_outs !== 82'd0) begin
      errors++; $display("FAIL arst_mid_outputs: got %h want 0", all_outs);
    end
    rready = 1'b0;
    arst = 1'b0;
    @(posedge clk); #1;
    wq = '{64'h0123_4567_89AB_CDEF};
    write_burst(4'h9, 32'h600, 8'd0, 3'd3, INCR, 8'hFF, 0, b_id, b_resp, to);
    checks++;
    if (to || {b_id, b_resp} !== {4'h9, 2'b00}) begin
      errors++; $display("FAIL post_arst_b: got id %h resp %b timeout %0d want id 9 resp 00", b_id, b_resp, to);
    end
    send_ar(4'hA, 32'h600, 8'd0, 3'd3, FIXED, to);
    exp_q.push_back({4'hA, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b1});
    recv_r(1, 0, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL post_arst_r: got no beat want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL post_arst_r: got %h want %h", o, e); end
      end
    end
  endtask

  initial begin
    arst = 1'b1;
    awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
    arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    rready = 1'b0;
    test_reset();
    test_single();
    test_incr_stall();
    test_wrap();
    test_strobe();
    test_errors();
    test_simultaneous();
    test_arst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
